carry_normalizer: RTL and testbench

//  Sequential carry-propagation stage after the digit-convolution core of the
//  FFT big-number multiplier. Accepts N_COEF raw convolution coefficients,

---
 rtl/carry_normalizer.sv | 138 +++++++++++++
 tb/tb_carry_normalizer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/carry_normalizer.sv
// Carry-propagation stage for the FFT big-number multiplier: resolves raw
// convolution coefficients LSD-first into decimal digits plus overflow/error flags.
module carry_normalizer #(
    parameter int N_COEF = 8,
    parameter int COEF_W = 32,
    parameter int DIG_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_COEF*COEF_W-1:0]   in_coef,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_COEF*DIG_W-1:0]    out_digit,
    output logic                       out_ovf,
    output logic                       out_err
);

    localparam int IDX_W = $clog2(N_COEF);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COEF - 1);
    localparam logic signed [COEF_W:0] TEN = (COEF_W+1)'(10);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef struct packed {
        logic signed [COEF_W:0] q;
        logic signed [COEF_W:0] r;
    } divmod_t;

    // Negative partial sums resolve to digit 0 with no carry; the error flag covers them.
    function automatic divmod_t divmod10(input logic signed [COEF_W:0] s);
        divmod_t res;
        if (s < 0) begin
            res.q = '0;
            res.r = '0;
        end else begin
            res.q = s / TEN;
            res.r = s % TEN;
        end
        return res;
    endfunction

    logic [1:0]               state;
    logic [IDX_W-1:0]         idx;
    logic signed [COEF_W:0]   carry;
    logic                     err_acc;
    logic                     ovf_r;
    logic                     err_r;
    logic signed [COEF_W-1:0] coef_r [N_COEF];
    logic [DIG_W-1:0]         work   [N_COEF];
    logic [DIG_W-1:0]         dig_r  [N_COEF];

    logic                     accept;
    logic                     in_neg;
    logic signed [COEF_W:0]   sum;
    divmod_t                  dm;
    logic [DIG_W-1:0]         new_digit;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_ovf   = ovf_r;
    assign out_err   = err_r;
    assign accept    = in_valid & in_ready;

    always_comb begin
        in_neg = 1'b0;
        for (int k = 0; k < N_COEF; k++) begin
            in_neg = in_neg | in_coef[(N_COEF-1-k)*COEF_W + COEF_W-1];
        end
    end

    always_comb begin
        sum       = {coef_r[idx][COEF_W-1], coef_r[idx]} + carry;
        dm        = divmod10(sum);
        new_digit = DIG_W'(dm.r);
    end

    always_comb begin
        out_digit = '0;
        for (int k = 0; k < N_COEF; k++) begin
            out_digit[(N_COEF-1-k)*DIG_W +: DIG_W] = dig_r[k];
        end
    end

    // Control and visible outputs: cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            carry   <= '0;
            err_acc <= 1'b0;
            ovf_r   <= 1'b0;
            err_r   <= 1'b0;
            for (int k = 0; k < N_COEF; k++) dig_r[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        idx     <= LAST_IDX;
                        carry   <= '0;
                        err_acc <= in_neg;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    carry <= dm.q;
                    if (idx == '0) begin
                        ovf_r    <= (dm.q != 0);
                        err_r    <= err_acc;
                        dig_r[0] <= new_digit;
                        for (int k = 1; k < N_COEF; k++) dig_r[k] <= work[k];
                        state    <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Working data: no reset needed, qualified by the FSM.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < N_COEF; k++) begin
                coef_r[k] <= in_coef[(N_COEF-1-k)*COEF_W +: COEF_W];
            end
        end
        if (state == RUN) work[idx] <= new_digit;
    end

endmodule

// File: tb/tb_carry_normalizer.sv
// Directed bench for carry_normalizer: table of coefficient vectors plus
// backpressure and mid-run reset sequences.
module tb_carry_normalizer;

    localparam int N  = 8;
    localparam int CW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [N*CW-1:0] in_coef;
    logic            out_valid;
    logic            out_ready;
    logic [N*DW-1:0] out_digit;
    logic            out_ovf;
    logic            out_err;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [N-1:0][CW-1:0] coef;
        logic [N-1:0][3:0]    dig;
        logic                 ovf;
        logic                 err;
    } vec_t;

    localparam int NV = 9;
    vec_t tbl [NV];

    carry_normalizer #(.N_COEF(N), .COEF_W(CW), .DIG_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_coef   (in_coef),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_digit (out_digit),
        .out_ovf   (out_ovf),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    // digits: decimal number whose 8 digits (MSD first) are the expected outputs
    function automatic vec_t mk(input int c0, input int c1, input int c2, input int c3,
                                input int c4, input int c5, input int c6, input int c7,
                                input int digits, input logic ovf, input logic err);
        vec_t v;
        int   d;
        v.coef[0] = CW'(c0); v.coef[1] = CW'(c1); v.coef[2] = CW'(c2); v.coef[3] = CW'(c3);
        v.coef[4] = CW'(c4); v.coef[5] = CW'(c5); v.coef[6] = CW'(c6); v.coef[7] = CW'(c7);
        d = digits;
        for (int k = N-1; k >= 0; k--) begin
            v.dig[k] = 4'(d % 10);
            d = d / 10;
        end
        v.ovf = ovf;
        v.err = err;
        return v;
    endfunction

    function automatic logic [N*DW-1:0] exp_bus(input vec_t v);
        logic [N*DW-1:0] b;
        b = '0;
        for (int k = 0; k < N; k++) b[(N-1-k)*DW +: DW] = DW'(v.dig[k]);
        return b;
    endfunction

    task automatic check(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive_coef(input vec_t v);
        for (int k = 0; k < N; k++) in_coef[(N-1-k)*CW +: CW] = v.coef[k];
    endtask

    // Leaves the bench 1 time unit into cycle 1 (first RUN cycle).
    task automatic start_vec(input vec_t v, input string tag);
        int t = 0;
        while (!in_ready && t < 30) begin
            @(posedge clk); #1; t++;
        end
        if (!in_ready) check({tag, "_in_ready_wait"}, 0, 1);
        drive_coef(v);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
        check({tag, "_latency"}, cyc, N + 1);
    endtask

    task automatic check_out(input vec_t v, input string tag);
        for (int k = 0; k < N; k++)
            check($sformatf("%s_dig%0d", tag, k), out_digit[(N-1-k)*DW +: DW], DW'(v.dig[k]));
        check({tag, "_ovf"}, out_ovf, v.ovf);
        check({tag, "_err"}, out_err, v.err);
        check({tag, "_in_ready_done"}, in_ready, 0);
    endtask

    task automatic pop(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        logic seen;

        tbl[0] = mk(0, 5, 16, 34, 60, 61, 52, 32,            7006652, 1'b0, 1'b0);
        tbl[1] = mk(0, 81, 162, 243, 324, 243, 162, 81,     99980001, 1'b0, 1'b0);
        tbl[2] = mk(0, 0, 0, 0, 0, 0, 0, 81,                      81, 1'b0, 1'b0);
        tbl[3] = mk(95, 0, 0, 0, 0, 0, 0, 0,                50000000, 1'b1, 1'b0);
        tbl[4] = mk(0, 0, 0, 0, 0, 0, -3, 4,                       4, 1'b0, 1'b1);
        tbl[5] = mk(9, 9, 9, 9, 9, 9, 9, 9,                 99999999, 1'b0, 1'b0);
        tbl[6] = mk(0, 0, 0, 0, 0, 0, 0, 12345,                12345, 1'b0, 1'b0);
        tbl[7] = mk(1000, 0, 0, 0, 0, 0, 0, 0,                     0, 1'b1, 1'b0);
        tbl[8] = mk(-1, 0, 0, 0, 0, 0, 0, 7,                       7, 1'b0, 1'b1);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_coef   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_digit", out_digit, 0);
        check("rst_ovf",       out_ovf,   0);
        check("rst_err",       out_err,   0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            start_vec(tbl[i], tag);
            wait_out(tag);
            check_out(tbl[i], tag);
            pop(tag);
        end

        // Backpressure: previous result held through RUN, then DONE held with a new vector waiting.
        start_vec(tbl[0], "bp");
        check("bp_retain_prev", out_digit, exp_bus(tbl[NV-1]));
        check("bp_run_valid", out_valid, 0);
        wait_out("bp");
        drive_coef(tbl[1]);
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d_valid", c), out_valid, 1);
            check($sformatf("bp_hold%0d_ready", c), in_ready, 0);
            check($sformatf("bp_hold%0d_digit", c), out_digit, exp_bus(tbl[0]));
        end
        check("bp_hold_ovf", out_ovf, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_idle_valid", out_valid, 0);
        check("bp_idle_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_accepted", in_ready, 0);
        wait_out("bp2");
        check_out(tbl[1], "bp2");
        pop("bp2");

        // Reset asserted in RUN cycle 4.
        start_vec(tbl[0], "rr");
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("rr_in_ready",  in_ready,  1);
        check("rr_out_valid", out_valid, 0);
        check("rr_out_digit", out_digit, 0);
        #2;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("rr_no_valid", seen, 0);
        check("rr_ready_after", in_ready, 1);
        start_vec(tbl[0], "rr2");
        wait_out("rr2");
        check_out(tbl[0], "rr2");
        pop("rr2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
